// File: rtl/cpu_bus_master.sv
// 65C02-style bus master: derives PHY2 from clk25 and runs read/write bus cycles
// from a one-deep command slot. Optional burst commands under CPU_BUS_MASTER_BURST_EN.
module cpu_bus_master #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned HALF_CYCLE = 6,
    parameter int unsigned ADDR_HOLD  = 1,
    parameter int unsigned DATA_SETUP = 3,
    parameter logic [15:0] CS_BASE    = 16'h9F20,
    parameter logic [15:0] CS_MASK    = 16'hFFE0
) (
    input  logic              clk25,
    input  logic              bus_res_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
`ifdef CPU_BUS_MASTER_BURST_EN
    input  logic [3:0]        cmd_len,
`endif
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [7:0]        rsp_rdata,
    output logic              bus_phy2,
    output logic [ADDR_W-1:0] bus_a,
    output logic              bus_cs_n,
    output logic              bus_rw_n,
    output logic [7:0]        bus_d_out,
    output logic              bus_d_oe,
    input  logic [7:0]        bus_d_in
);

    localparam int unsigned       CNT_W      = $clog2(HALF_CYCLE);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(HALF_CYCLE - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'((ADDR_HOLD == 0) ? 0 : ADDR_HOLD - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'((DATA_SETUP == 0) ? 0 : DATA_SETUP - 1);
    localparam logic [ADDR_W-1:0] CS_BASE_W  = ADDR_W'(CS_BASE);
    localparam logic [ADDR_W-1:0] CS_MASK_W  = ADDR_W'(CS_MASK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phy2_d;
    logic                slot_full_q, slot_full_d;
    logic                slot_write_q, slot_write_d;
    logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [7:0]          slot_wdata_q, slot_wdata_d;
    logic                act_write_q, act_write_d;
    logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
    logic [7:0]          act_wdata_q, act_wdata_d;
    logic                cmd_ready_d;
    logic                rsp_valid_d, rsp_write_d;
    logic [7:0]          rsp_rdata_d;
    logic [ADDR_W-1:0]   bus_a_d;
    logic                bus_cs_n_d, bus_rw_n_d, bus_d_oe_d;
    logic [7:0]          bus_d_out_d;
`ifdef CPU_BUS_MASTER_BURST_EN
    logic [3:0]          slot_len_q, slot_len_d;
    logic [3:0]          rem_q, rem_d;
`endif

    logic wrap_c, fall_c, rise_c, apply_c, setup_c, take_c, accept_c;

    // Phase decode: fall/rise are the edges at which bus_phy2 will toggle
    assign wrap_c   = (cnt_q == CNT_LAST);
    assign fall_c   = wrap_c & bus_phy2;
    assign rise_c   = wrap_c & ~bus_phy2;
    assign apply_c  = (ADDR_HOLD == 0) ? fall_c : (~bus_phy2 && (cnt_q == HOLD_LAST));
    assign setup_c  = (DATA_SETUP == 0) ? rise_c : (bus_phy2 && (cnt_q == SETUP_LAST));
    assign accept_c = cmd_valid & cmd_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = wrap_c ? '0 : cnt_q + CNT_W'(1);
        phy2_d       = bus_phy2 ^ wrap_c;
        slot_full_d  = slot_full_q;
        slot_write_d = slot_write_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        act_write_d  = act_write_q;
        act_addr_d   = act_addr_q;
        act_wdata_d  = act_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_write_d  = rsp_write;
        rsp_rdata_d  = rsp_rdata;
        bus_a_d      = bus_a;
        bus_cs_n_d   = bus_cs_n;
        bus_rw_n_d   = bus_rw_n;
        bus_d_out_d  = bus_d_out;
        bus_d_oe_d   = bus_d_oe;
        take_c       = 1'b0;
`ifdef CPU_BUS_MASTER_BURST_EN
        slot_len_d   = slot_len_q;
        rem_d        = rem_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (fall_c && slot_full_q) take_c = 1'b1;
            end
            ST_LOW: begin
                if (rise_c) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = act_write_q;
                    rsp_rdata_d = act_write_q ? 8'h00 : bus_d_in;
                    state_d     = ST_IDLE;
`ifdef CPU_BUS_MASTER_BURST_EN
                    if (rem_q != 4'd0) begin
                        state_d    = ST_LOW;
                        act_addr_d = act_addr_q + ADDR_W'(1);
                        rem_d      = rem_q - 4'd1;
                    end else if (slot_full_q) begin
                        take_c = 1'b1;
                    end
`else
                    if (slot_full_q) take_c = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Slot hands its command to the active register at a fall edge
        if (take_c) begin
            state_d     = ST_LOW;
            act_write_d = slot_write_q;
            act_addr_d  = slot_addr_q;
            act_wdata_d = slot_wdata_q;
            slot_full_d = 1'b0;
`ifdef CPU_BUS_MASTER_BURST_EN
            rem_d       = slot_len_q;
`endif
        end

        if (accept_c) begin
            slot_full_d  = 1'b1;
            slot_write_d = cmd_write;
            slot_addr_d  = cmd_addr;
            slot_wdata_d = cmd_wdata;
`ifdef CPU_BUS_MASTER_BURST_EN
            slot_len_d   = cmd_len;
`endif
        end

        // End of address hold: present the new cycle or return the bus to idle
        if (apply_c) begin
            bus_d_oe_d = 1'b0;
            if (state_d == ST_LOW) begin
                bus_a_d    = act_addr_d;
                bus_rw_n_d = ~act_write_d;
                bus_cs_n_d = ((act_addr_d & CS_MASK_W) != CS_BASE_W);
            end else begin
                bus_a_d    = '0;
                bus_rw_n_d = 1'b1;
                bus_cs_n_d = 1'b1;
            end
        end

        if (setup_c && (state_d == ST_HIGH) && act_write_d) begin
            bus_d_out_d = act_wdata_d;
            bus_d_oe_d  = 1'b1;
        end

`ifdef CPU_BUS_MASTER_BURST_EN
        cmd_ready_d = ~slot_full_d & (rem_d == 4'd0);
`else
        cmd_ready_d = ~slot_full_d;
`endif
    end

    always_ff @(posedge clk25) begin
        if (!bus_res_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bus_phy2     <= 1'b0;
            slot_full_q  <= 1'b0;
            slot_write_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            act_write_q  <= 1'b0;
            act_addr_q   <= '0;
            act_wdata_q  <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
            bus_a        <= '0;
            bus_cs_n     <= 1'b1;
            bus_rw_n     <= 1'b1;
            bus_d_out    <= '0;
            bus_d_oe     <= 1'b0;
`ifdef CPU_BUS_MASTER_BURST_EN
            slot_len_q   <= '0;
            rem_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_phy2     <= phy2_d;
            slot_full_q  <= slot_full_d;
            slot_write_q <= slot_write_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            act_write_q  <= act_write_d;
            act_addr_q   <= act_addr_d;
            act_wdata_q  <= act_wdata_d;
            cmd_ready    <= cmd_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_write    <= rsp_write_d;
            rsp_rdata    <= rsp_rdata_d;
            bus_a        <= bus_a_d;
            bus_cs_n     <= bus_cs_n_d;
            bus_rw_n     <= bus_rw_n_d;
            bus_d_out    <= bus_d_out_d;
            bus_d_oe     <= bus_d_oe_d;
`ifdef CPU_BUS_MASTER_BURST_EN
            slot_len_q   <= slot_len_d;
            rem_q        <= rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: random commands, edge-count timing model, response scoreboard.
module tb_cpu_bus_master;

    localparam int HC = 6;
    localparam int AH = 1;
    localparam int DS = 3;
    localparam int P  = 2 * HC;

    logic        clk25;
    logic        bus_res_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [7:0]  rsp_rdata;
    logic        bus_phy2;
    logic [15:0] bus_a;
    logic        bus_cs_n;
    logic        bus_rw_n;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_d_in;

    logic [7:0]  mem [256];
    assign bus_d_in = mem[bus_a[7:0]];

    cpu_bus_master #(
        .ADDR_W(16), .HALF_CYCLE(HC), .ADDR_HOLD(AH), .DATA_SETUP(DS),
        .CS_BASE(16'h9F20), .CS_MASK(16'hFFE0)
    ) dut (
        .clk25(clk25), .bus_res_n(bus_res_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .bus_phy2(bus_phy2), .bus_a(bus_a), .bus_cs_n(bus_cs_n), .bus_rw_n(bus_rw_n),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in)
    );

    typedef struct {
        int          kf;
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } cyc_t;

    typedef struct {
        int         k;
        logic       w;
        logic [7:0] rd;
    } rsp_t;

    cyc_t sched[$];
    rsp_t sbq[$];
    int   k = 0;
    int   last_kf = 0;
    bit   in_rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    initial begin
        clk25 = 1'b0;
        forever #5 clk25 = ~clk25;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", nm, got, exp, k);
        end
    endtask

    // Reference model: edge index k since reset release; phy2 falls when k is a multiple of 2*HC
    initial forever begin
        @(posedge clk25);
        if (!bus_res_n) begin
            in_rst  = 1'b1;
            k       = 0;
            last_kf = 0;
            sched.delete();
            sbq.delete();
        end else begin
            in_rst = 1'b0;
            k++;
            if (cmd_valid && cmd_ready) begin
                int nf;
                int kf;
                cyc_t c;
                rsp_t r;
                nf = (k / P + 1) * P;
                kf = (nf > last_kf + P) ? nf : last_kf + P;
                c.kf = kf; c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
                sched.push_back(c);
                r.k = kf + P; r.w = cmd_write;
                r.rd = cmd_write ? 8'h00 : mem[cmd_addr[7:0]];
                sbq.push_back(r);
                last_kf = kf;
            end
        end
    end

    // Monitor: compares bus pins and responses against the model, away from the active edge
    initial forever begin
        @(negedge clk25);
        if (in_rst) begin
            chk("rst_phy2", 32'(bus_phy2), 0);
            chk("rst_a", 32'(bus_a), 0);
            chk("rst_rw_n", 32'(bus_rw_n), 1);
            chk("rst_cs_n", 32'(bus_cs_n), 1);
            chk("rst_d_oe", 32'(bus_d_oe), 0);
            chk("rst_d_out", 32'(bus_d_out), 0);
            chk("rst_ready", 32'(cmd_ready), 1);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_write", 32'(rsp_write), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        end else begin
            logic [15:0] ea;
            logic        erw, ecs, eoe;
            logic [7:0]  ed;
            while (sched.size() > 0 && k >= sched[0].kf + P + AH) void'(sched.pop_front());
            ea = 16'h0; erw = 1'b1; ecs = 1'b1; eoe = 1'b0; ed = 8'h00;
            if (sched.size() > 0 && k >= sched[0].kf + AH) begin
                ea  = sched[0].a;
                erw = ~sched[0].w;
                ecs = ((sched[0].a & 16'hFFE0) != 16'h9F20);
                eoe = sched[0].w && (k - sched[0].kf >= HC + DS);
                ed  = sched[0].d;
            end
            chk("phy2", 32'(bus_phy2), 32'((k / HC) % 2));
            chk("bus_a", 32'(bus_a), 32'(ea));
            chk("rw_n", 32'(bus_rw_n), 32'(erw));
            chk("cs_n", 32'(bus_cs_n), 32'(ecs));
            chk("d_oe", 32'(bus_d_oe), 32'(eoe));
            if (eoe) chk("d_out", 32'(bus_d_out), 32'(ed));
            chk("cmd_ready", 32'(cmd_ready), 32'(k >= last_kf));
            if (sbq.size() > 0 && sbq[0].k < k) begin
                chk("rsp_missing", 32'(k), 32'(sbq[0].k));
                void'(sbq.pop_front());
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    rsp_t r;
                    r = sbq.pop_front();
                    chk("rsp_edge", 32'(k), 32'(r.k));
                    chk("rsp_write", 32'(rsp_write), 32'(r.w));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rd));
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk25);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk25);
            if (cmd_ready) done = 1'b1;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom()); cmd_addr = 16'($urandom()); cmd_wdata = 8'($urandom());
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h9F20 | 16'($urandom_range(0, 31));
            1:       return 16'h9F40 | 16'($urandom_range(0, 31));
            2:       return 16'h9F1F;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        bus_res_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
        mem[8'h21] = 8'h5C;
        repeat (3) @(posedge clk25);
        #1 bus_res_n = 1'b1;
        repeat (30) @(posedge clk25);

        // Directed: CS write, CS read, non-CS read, then an immediate back-to-back pair
        issue(1'b1, 16'h9F20, 8'hAA);
        issue(1'b0, 16'h9F21, 8'h00);
        issue(1'b0, 16'h1000, 8'h00);
        repeat (40) @(posedge clk25);
        issue(1'b1, 16'h9F3F, 8'h12);
        issue(1'b1, 16'h9F00, 8'h34);
        repeat (40) @(posedge clk25);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk25);
            issue(1'($urandom()), rand_addr(), 8'($urandom()));
        end
        for (int n = 0; n < 300 && sbq.size() > 0; n++) @(negedge clk25);

        // Reset during HIGH of a write while a second command is pending
        issue(1'b1, 16'h9F20, 8'h77);
        issue(1'b0, 16'h9F21, 8'h00);
        for (int n = 0; n < 100 && k < last_kf - P + HC + DS + 1; n++) @(negedge clk25);
        chk("pre_reset_oe", 32'(bus_d_oe), 1);
        bus_res_n = 1'b0;
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        bus_res_n = 1'b1;
        repeat (30) @(posedge clk25);

        issue(1'b0, 16'h9F21, 8'h00);
        issue(1'b1, 16'hFFFF, 8'hC3);
        for (int n = 0; n < 300 && sbq.size() > 0; n++) @(negedge clk25);
        chk("drain", 32'(sbq.size()), 0);
        repeat (30) @(posedge clk25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
